// File: rtl/io_pkg.sv
// Shared types and constants for the SPI register bank.
// Holds the FSM state type, the bank size default and the ID byte.
package io_pkg;

  localparam int REGCOUNT_DEF = 16;

  localparam logic [7:0] ID_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } spi_state_t;

  function automatic logic [6:0] addr_inc(
    input logic [6:0] a,
    input int         rc
  );
    if (int'(a) == rc - 1) return 7'd0;
    return a + 7'd1;
  endfunction

endpackage

// File: rtl/spi_reg_bank_sync2.sv
// Two-flop synchronizer with a selectable idle level.
// Used for every asynchronous SPI pin.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 slave exposing a byte-wide register bank.
// Byte 0 is a fixed ID; other bytes are written over SPI.
module spi_reg_bank
  import io_pkg::*;
#(
  parameter int REGCOUNT = REGCOUNT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [8*REGCOUNT-1:0] registers_packed,
  output logic                  wr_strobe,
  output logic [6:0]            wr_addr
);

  logic sclk_s, cs_s, mosi_s;

  sync2 #(.RST_VAL(1'b0)) u_sync_sclk (
    .clock(clock), .reset(reset),
    .d(sclk), .q(sclk_s)
  );

  sync2 #(.RST_VAL(1'b1)) u_sync_cs (
    .clock(clock), .reset(reset),
    .d(cs_n), .q(cs_s)
  );

  sync2 #(.RST_VAL(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset),
    .d(mosi), .q(mosi_s)
  );

  spi_state_t  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [6:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic        sclk_dly_q, sclk_dly_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [1:0]  settle_q, settle_d;
  logic        armed_q, armed_d;
  logic [7:0]  regs_q [1:REGCOUNT-1];
  logic [7:0]  regs_d [1:REGCOUNT-1];

  logic        sclk_rise, sclk_fall;
  logic [7:0]  rx_byte;
  logic [6:0]  addr_nxt;

  function automatic logic [7:0] rd_byte(
    input logic [6:0] a
  );
    logic [7:0] v;
    v = 8'h00;
    if (a == 7'd0) v = ID_BYTE;
    for (int i = 1; i < REGCOUNT; i++)
      if (a == 7'(i)) v = regs_q[i];
    return v;
  endfunction

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign rx_byte   = {shift_q[6:0], mosi_s};
  assign addr_nxt  = addr_inc(addr_q, REGCOUNT);

  // A frame may only start once cs_n has been seen high on real
  // synchronized data, so a frame cut by reset stays ignored.
  always_comb begin
    sclk_dly_d  = sclk_s;
    settle_d    = settle_q[1] ? settle_q : settle_q + 2'd1;
    armed_d     = armed_q | (cs_s & settle_q[1]);
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    addr_d      = addr_q;
    rw_d        = rw_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    regs_d      = regs_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!cs_s && armed_q) begin
          state_d = ST_CMD;
          cnt_d   = 3'd0;
          shift_d = 8'h00;
        end
      end
      ST_CMD: begin
        if (cs_s) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (sclk_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = ST_DATA;
            rw_d    = rx_byte[7];
            addr_d  = rx_byte[6:0];
            tx_d    = rx_byte[7] ? rd_byte(rx_byte[6:0]) : 8'h00;
          end
        end
      end
      ST_DATA: begin
        if (cs_s) begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end else if (sclk_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            addr_d = addr_nxt;
            if (rw_q) begin
              tx_d = rd_byte(addr_nxt);
            end else if (addr_q != 7'd0 && int'(addr_q) < REGCOUNT) begin
              for (int i = 1; i < REGCOUNT; i++)
                if (addr_q == 7'(i)) regs_d[i] = rx_byte;
              wr_strobe_d = 1'b1;
              wr_addr_d   = addr_q;
            end
          end
        end else if (sclk_fall && rw_q && cnt_q != 3'd0) begin
          // No shift on the fall right after a byte load.
          tx_d = {tx_q[6:0], 1'b0};
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      shift_q     <= 8'h00;
      tx_q        <= 8'h00;
      addr_q      <= 7'd0;
      rw_q        <= 1'b0;
      sclk_dly_q  <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 7'd0;
      settle_q    <= 2'd0;
      armed_q     <= 1'b0;
      for (int i = 1; i < REGCOUNT; i++)
        regs_q[i] <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      tx_q        <= tx_d;
      addr_q      <= addr_d;
      rw_q        <= rw_d;
      sclk_dly_q  <= sclk_dly_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      settle_q    <= settle_d;
      armed_q     <= armed_d;
      regs_q      <= regs_d;
    end
  end

  always_comb begin
    registers_packed      = '0;
    registers_packed[7:0] = ID_BYTE;
    for (int i = 1; i < REGCOUNT; i++)
      registers_packed[8*i +: 8] = regs_q[i];
  end

  assign miso      = (state_q == ST_DATA) && rw_q && tx_q[7];
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;

endmodule
